dmem_bus_master: RTL
====================

Name: dmem_bus_master

Overview:
- Processor-side initiator for the external data-memory bus (DAD/MREQ/WRITE/SIZE/DDT/ACKD_n).
- Accepts one load or store per transaction from the pipeline memory stage and runs the bus cycle; the external memory model is the responder.
- Formats write data into bus lanes (big-endian) and returns load data extended to 32 bits.
- Checks alignment and reports errors.

Parameters:
- BIT_WIDTH, 32, data and address width.
- TIMEOUT_CYCLES, 64, maximum REQ cycles before the watchdog aborts (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  pipeline request strobe; sampled only when req_ready=1.
- req_ready  out  1  block is IDLE and can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=word, 01=halfword, 10=byte; 11 is illegal.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; value right-aligned in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; valid with resp_valid; 0 for stores.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size, or timeout.
- DAD  out  32  bus address.
- MREQ  out  1  bus request.
- WRITE  out  1  bus direction, 1=write.
- SIZE  out  2  bus transfer size, same encoding as req_size.
- ACKD_n  in  1  responder acknowledge, active-low.
- DDT  inout  32  bus data.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MREQ=0, WRITE=0, SIZE=00, DAD=0; DDT released (high-Z).
- rst asserted in any state returns to IDLE on the next edge; any in-flight bus cycle is dropped and no resp_valid is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE, accepting a request (req_valid & req_ready):
  - Latch addr, write, size, signed, wdata.
  - Error check: size=11, halfword with addr[0]=1, or word with addr[1:0]!=0 -> go to RESP with resp_err=1 and no bus cycle (MREQ stays 0).
  - Otherwise -> REQ.
- REQ:
  - Outputs: MREQ=1, DAD=latched addr, WRITE=latched write, SIZE=latched size.
  - ACKD_n is sampled at each rising edge, only while in REQ.
  - ACKD_n=0 -> go to RESP; a load captures DDT in the same edge.
  - Minimum REQ duration is 1 cycle. Total latency from acceptance to resp_valid is (ack cycles + 1).
- Store lane placement, driven on DDT only while in REQ with WRITE=1:
  - word: wdata[31:0].
  - halfword: {16'h0, wdata[15:0]}.
  - byte: {24'h0, wdata[7:0]}.
  - DDT is high-Z in every other state and on loads.
- Load extraction: the responder returns halfword and byte data right-aligned, upper bits zero.
  - byte: resp_rdata = req_signed ? sign-extend DDT[7:0] : zero-extend DDT[7:0].
  - halfword: same rule using DDT[15:0].
  - word: DDT[31:0] unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle, MREQ=0, then go to IDLE.
  - req_ready=0 in REQ and RESP, so the next request is accepted no earlier than the cycle after resp_valid.
- Address 32'hF000_0000 (stdout) and 32'hFF00_0000 (exit) receive no special handling; they pass through as normal bus cycles.
- req_valid held high while req_ready=0 has no effect; requests are not queued.

Optional Feature:
- Macro: DMEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to REQ and increments each REQ cycle with ACKD_n=1.
  - When the count reaches TIMEOUT_CYCLES: drop MREQ, go to RESP with resp_err=1, resp_rdata=0.
  - An ack arriving in the same cycle as the timeout wins; the transaction completes normally.
- Not defined: no counter is built, and REQ waits indefinitely for ACKD_n.

Test Plan:
- Word load, addr 0x100, responder returns 0x DEADBEEF with 1-cycle latency -> MREQ=1, WRITE=0, SIZE=00 for 1 cycle; resp_valid 2 cycles after acceptance with resp_rdata=0xDEADBEEF, resp_err=0.
- Signed byte load, addr 0x103, DDT=0x00000080 -> resp_rdata=0xFFFFFF80. Same access unsigned -> 0x00000080.
- Halfword store, addr 0x202, wdata=0x12345678 -> DDT=0x00005678, SIZE=01, WRITE=1 while in REQ; DDT high-Z after.
- Misaligned word load, addr 0x101 -> MREQ never rises; resp_valid next cycle with resp_err=1. Same for req_size=11.
- Responder latency 3, with rst asserted in the 2nd REQ cycle -> MREQ=0 and req_ready=1 after that edge; no resp_valid.
- With DMEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ACKD_n held at 1 -> MREQ high 4 cycles, then resp_valid with resp_err=1.

Source files
------------

// File: rtl/dmem_bus_master_if.sv
// Pipeline-side request/response bundle for dmem_bus_master.
// master = pipeline memory stage, slave = dmem_bus_master.
interface dmem_bus_master_if #(
  parameter int BIT_WIDTH = 32
);
  // A request transfers on a rising edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no back-pressure.
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [BIT_WIDTH-1:0] req_addr;
  logic [BIT_WIDTH-1:0] req_wdata;
  logic                 resp_valid;
  logic [BIT_WIDTH-1:0] resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bus_master.sv
// Data-memory bus initiator: one load/store per transaction, big-endian lane
// formatting, load extension, alignment errors. Optional watchdog: DMEM_BUS_TIMEOUT_EN.
module dmem_bus_master #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_master_if.slave     pipe,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  tri   [BIT_WIDTH-1:0] DDT,
  output logic [1:0]           dbg_state_o,
  output logic                 dbg_ddt_oe_o
);
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q, addr_d;
  logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic                 write_q, write_d;
  logic                 signed_q, signed_d;
  logic                 err_q, err_d;
  logic [1:0]           size_q, size_d;

  logic                 req_bad;
  logic                 ack;
  logic                 timeout;
  logic [BIT_WIDTH-1:0] load_ext;
  logic [BIT_WIDTH-1:0] store_lane;

  assign ack = !ACKD_n;

  always_comb begin
    req_bad = 1'b0;
    case (pipe.req_size)
      SZ_WORD: req_bad = (pipe.req_addr[1:0] != 2'b00);
      SZ_HALF: req_bad = pipe.req_addr[0];
      SZ_BYTE: req_bad = 1'b0;
      default: req_bad = 1'b1;
    endcase
  end

  // The responder returns sub-word data right-aligned, so extension is from bit 7/15.
  always_comb begin
    load_ext = DDT;
    case (size_q)
      SZ_HALF: load_ext = {{(BIT_WIDTH-16){signed_q & DDT[15]}}, DDT[15:0]};
      SZ_BYTE: load_ext = {{(BIT_WIDTH-8){signed_q & DDT[7]}}, DDT[7:0]};
      default: load_ext = DDT;
    endcase
  end

  always_comb begin
    store_lane = wdata_q;
    case (size_q)
      SZ_HALF: store_lane = {{(BIT_WIDTH-16){1'b0}}, wdata_q[15:0]};
      SZ_BYTE: store_lane = {{(BIT_WIDTH-8){1'b0}}, wdata_q[7:0]};
      default: store_lane = wdata_q;
    endcase
  end

`ifdef DMEM_BUS_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  // Counts completed REQ cycles; an ack in the limit cycle still takes priority.
  assign wait_d  = (state_q == S_REQ) ? wait_q + 8'd1 : 8'd0;
  assign timeout = (state_q == S_REQ) && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) wait_q <= 8'd0;
    else     wait_q <= wait_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    write_d  = write_q;
    signed_d = signed_q;
    err_d    = err_q;
    size_d   = size_q;
    case (state_q)
      S_IDLE: begin
        if (pipe.req_valid) begin
          addr_d   = pipe.req_addr;
          wdata_d  = pipe.req_wdata;
          write_d  = pipe.req_write;
          signed_d = pipe.req_signed;
          size_d   = pipe.req_size;
          rdata_d  = '0;
          err_d    = req_bad;
          state_d  = req_bad ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          rdata_d = write_q ? '0 : load_ext;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      size_q   <= size_d;
    end
  end

  assign pipe.req_ready  = (state_q == S_IDLE);
  assign pipe.resp_valid = (state_q == S_RESP);
  assign pipe.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
  assign pipe.resp_err   = (state_q == S_RESP) && err_q;

  // Bus address/control read as zero outside a bus cycle.
  assign MREQ  = (state_q == S_REQ);
  assign DAD   = MREQ ? addr_q : '0;
  assign WRITE = MREQ && write_q;
  assign SIZE  = MREQ ? size_q : 2'b00;

  assign dbg_ddt_oe_o = MREQ && write_q;
  assign DDT          = dbg_ddt_oe_o ? store_lane : 'z;
  assign dbg_state_o  = state_q;
endmodule
